pulse_event_arbiter: RTL and testbench

PULSE_EVENT_ARBITER -- requirements
Module: pulse_event_arbiter

---
 rtl/pulse_event_arbiter_pkg.sv | 10 +
 rtl/pulse_event_arbiter_edge_pulse.sv | 27 ++
 rtl/pulse_event_arbiter.sv | 118 +++++++++++
 tb/tb_pulse_event_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_event_arbiter_pkg.sv
// Shared constants for the pulse event arbiter: FSM encoding and default sizing.
package pulse_event_arbiter_pkg;

    localparam int N_CH_DEF = 4;
    localparam int ID_W_DEF = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

endpackage

// File: rtl/pulse_event_arbiter_edge_pulse.sv
// Two-stage register of one level input; emits a single-cycle pulse per rising transition.
module edge_pulse
    import pulse_event_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic r1_q;
    logic r2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_q <= 1'b0;
            r2_q <= 1'b0;
        end else begin
            r1_q <= din;
            r2_q <= r1_q;
        end
    end

    // r2 clears on reset, so a level already high at release yields one pulse.
    assign pulse = r1_q & ~r2_q;

endmodule

// File: rtl/pulse_event_arbiter.sv
// Collects rising-edge events per channel into pending flags and offers them one at a time,
// round-robin, over a valid/ready handshake with sticky per-channel overflow flags.
module pulse_event_arbiter
    import pulse_event_arbiter_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    input  logic            evt_ready,
    output logic [N_CH-1:0] pend,
    output logic [N_CH-1:0] ovf,
    input  logic [N_CH-1:0] ovf_clr
);

    logic [N_CH-1:0] edge_det;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] ovf_q, ovf_d;
    logic [N_CH-1:0] clr_mask;
    logic [0:0]      state_q, state_d;
    logic [ID_W-1:0] evt_id_q, evt_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic            hs;
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [ID_W:0]   rr_sum;
    logic [ID_W-1:0] rr_idx;

    for (genvar g = 0; g < N_CH; g++) begin : g_edge
        edge_pulse u_edge (
            .clk   (clk),
            .rst   (rst),
            .din   (din[g]),
            .pulse (edge_det[g])
        );
    end

    assign hs = (state_q == ST_OFFER) && evt_ready;

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            clr_mask[i] = hs && (evt_id_q == ID_W'(i));
        end
    end

    // Set beats clear; a new edge on an already pending, uncleared channel is merged and flagged.
    always_comb begin
        pend_d = (pend_q & ~clr_mask) | edge_det;
        ovf_d  = (ovf_q & ~ovf_clr) | (edge_det & pend_q & ~clr_mask);
    end

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int off = 1; off <= N_CH; off++) begin
            rr_sum = {1'b0, last_grant_q} + (ID_W+1)'(off);
            if (rr_sum >= (ID_W+1)'(N_CH)) begin
                rr_sum = rr_sum - (ID_W+1)'(N_CH);
            end
            rr_idx = rr_sum[ID_W-1:0];
            if (!win_found && pend_q[rr_idx]) begin
                win_found = 1'b1;
                win_id    = rr_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        evt_id_d     = evt_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d  = ST_OFFER;
                    evt_id_d = win_id;
                end
            end
            ST_OFFER: begin
                // The offer is held until accepted; returning to IDLE creates the bubble cycle.
                if (evt_ready) begin
                    state_d      = ST_IDLE;
                    last_grant_d = evt_id_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= '0;
            ovf_q        <= '0;
            state_q      <= ST_IDLE;
            evt_id_q     <= '0;
            last_grant_q <= ID_W'(N_CH - 1);
        end else begin
            pend_q       <= pend_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            evt_id_q     <= evt_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign evt_valid = (state_q == ST_OFFER);
    assign evt_id    = evt_id_q;
    assign pend      = pend_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Scoreboard bench for pulse_event_arbiter: expected grant ids are queued when stimulus is
// applied and compared as handshakes occur, alongside cycle-exact timing checks.
module tb_pulse_event_arbiter;

    localparam int N_CH = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] din = '0;
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready = 1'b0;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] ovf;
    logic [N_CH-1:0] ovf_clr = '0;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;
    int exp_q[$];

    pulse_event_arbiter #(.N_CH(N_CH), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .pend      (pend),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        check("sb_drained", exp_q.size(), 0);
        rst = 1'b1;
        din = '0;
        evt_ready = 1'b0;
        ovf_clr = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Inputs only change #1 after a rising edge, so what is seen here is what the next edge sees.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_evt", {30'd0, evt_id}, 32'hFFFF_FFFF);
            end else begin
                check("sb_evt_id", {30'd0, evt_id}, exp_q.pop_front());
            end
        end
    end

    initial begin
        int hs0;

        // Reset state
        #2;
        check("rst_valid", evt_valid, 0);
        check("rst_id", evt_id, 0);
        check("rst_pend", pend, 0);
        check("rst_ovf", ovf, 0);
        do_reset();

        // Single event on channel 2
        evt_ready = 1'b1;
        din[2] = 1'b1;
        exp_q.push_back(2);
        tick();
        check("single_valid_k1", evt_valid, 0);
        check("single_pend_k1", pend, 4'b0000);
        tick();
        check("single_valid_k2", evt_valid, 0);
        check("single_pend_k2", pend, 4'b0100);
        tick();
        check("single_valid_k3", evt_valid, 1);
        check("single_id_k3", evt_id, 2);
        tick();
        check("single_valid_k4", evt_valid, 0);
        check("single_pend_k4", pend, 4'b0000);
        din = '0;
        repeat (3) tick();
        check("single_no_repeat", evt_valid, 0);
        do_reset();

        // Fairness: all four channels at once
        evt_ready = 1'b1;
        din = 4'b1111;
        for (int k = 0; k < N_CH; k++) exp_q.push_back(k);
        tick();
        din = '0;
        tick();
        tick();
        for (int k = 0; k < N_CH; k++) begin
            check("rr_valid", evt_valid, 1);
            check("rr_id", evt_id, k);
            tick();
            check("rr_bubble", evt_valid, 0);
            if (k < N_CH - 1) tick();
        end
        check("rr_pend_empty", pend, 0);
        do_reset();

        // Backpressure on channel 1
        din[1] = 1'b1;
        exp_q.push_back(1);
        repeat (3) tick();
        check("bp_valid_start", evt_valid, 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_valid_hold", evt_valid, 1);
            check("bp_id_hold", evt_id, 1);
            check("bp_pend_hold", pend, 4'b0010);
        end
        evt_ready = 1'b1;
        tick();
        check("bp_valid_after", evt_valid, 0);
        check("bp_pend_after", pend, 0);
        din = '0;
        do_reset();

        // Overflow on channel 3: two pulses while not ready
        din[3] = 1'b1;
        exp_q.push_back(3);
        tick();
        din[3] = 1'b0;
        tick();
        din[3] = 1'b1;
        tick();
        din[3] = 1'b0;
        check("ovf_valid_k3", evt_valid, 1);
        check("ovf_ovf_k3", ovf, 0);
        tick();
        check("ovf_set", ovf, 4'b1000);
        check("ovf_pend", pend, 4'b1000);
        check("ovf_id", evt_id, 3);
        hs0 = hs_cnt;
        evt_ready = 1'b1;
        tick();
        check("ovf_valid_after_hs", evt_valid, 0);
        check("ovf_pend_after_hs", pend, 0);
        check("ovf_sticky", ovf, 4'b1000);
        repeat (4) tick();
        check("ovf_one_event", hs_cnt - hs0, 1);
        ovf_clr[3] = 1'b1;
        tick();
        ovf_clr = '0;
        check("ovf_cleared", ovf, 0);
        do_reset();

        // Coincident set and clear on channel 0
        evt_ready = 1'b1;
        din[0] = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(0);
        tick();
        din[0] = 1'b0;
        tick();
        din[0] = 1'b1;
        tick();
        din[0] = 1'b0;
        check("coin_valid_first", evt_valid, 1);
        check("coin_id_first", evt_id, 0);
        tick();
        check("coin_pend_kept", pend, 4'b0001);
        check("coin_no_ovf", ovf, 0);
        check("coin_bubble", evt_valid, 0);
        tick();
        check("coin_valid_second", evt_valid, 1);
        check("coin_id_second", evt_id, 0);
        tick();
        check("coin_valid_done", evt_valid, 0);
        check("coin_pend_done", pend, 0);
        do_reset();

        // Asynchronous reset in the middle of an offer
        din[1] = 1'b1;
        repeat (3) tick();
        check("arst_offer", evt_valid, 1);
        check("arst_offer_id", evt_id, 1);
        #2;
        rst = 1'b1;
        din = 4'b0001;
        #1;
        check("arst_valid_now", evt_valid, 0);
        check("arst_pend_now", pend, 0);
        check("arst_id_now", evt_id, 0);
        tick();
        tick();
        rst = 1'b0;
        evt_ready = 1'b1;
        exp_q.push_back(0);
        hs0 = hs_cnt;
        tick();
        tick();
        check("arst_valid_k2", evt_valid, 0);
        tick();
        check("arst_valid_k3", evt_valid, 1);
        check("arst_id_k3", evt_id, 0);
        repeat (5) tick();
        check("arst_one_event", hs_cnt - hs0, 1);
        check("arst_pend_end", pend, 0);
        din = '0;

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
